// File: rtl/parity_tx_ctrl_pkg.sv
// Shared definitions for the parity transmit sequencer: FSM encoding,
// frame geometry and parity-mode constants.
package parity_tx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 7;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Odd mode flips the even-parity bit so the 8-bit word has an odd ones count.
    function automatic logic [DATA_BITS:0] add_parity(input logic [DATA_BITS-1:0] data,
                                                      input logic                 mode);
        return {(^data) ^ (mode == ODD), data};
    endfunction

endpackage

// File: rtl/parity_tx_ctrl_par_calc.sv
// Combinational parity appender feeding the holding register.
module par_calc
    import parity_tx_ctrl_pkg::*;
(
    input  logic [DATA_BITS-1:0] data,
    input  logic                 mode,
    output logic [DATA_BITS:0]   word
);

    assign word = add_parity(data, mode);

endmodule

// File: rtl/parity_tx_ctrl.sv
// Parity transmit sequencer: one-entry holding register in front of a
// start/8-data/stop serialiser with back-to-back frame chaining.
module parity_tx_ctrl
    import parity_tx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 par_mode,
    output logic                 tx,
    output logic                 busy,
    output logic [DATA_BITS:0]   frame_out,
    output logic                 frame_valid
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS);

    tx_state_t          state;
    tx_state_t          state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [2:0]         idx;
    logic [2:0]         idx_next;
    logic [DATA_BITS:0] shifter;
    logic [DATA_BITS:0] shifter_next;
    logic [DATA_BITS:0] hold_data;
    logic [DATA_BITS:0] par_word;
    logic               hold_full;
    logic               transfer;
    logic               load;
    logic               bit_done;
    logic               tx_next;
    logic               busy_next;

    par_calc u_par_calc (
        .data (in_data),
        .mode (par_mode),
        .word (par_word)
    );

    assign in_ready = ~hold_full;
    assign transfer = in_valid & ~hold_full;
    assign bit_done = (cnt == CNT_LAST);

    // Load and transfer are mutually exclusive: load needs a full slot, transfer an empty one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (transfer) begin
            hold_full <= 1'b1;
            hold_data <= par_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shifter     <= '0;
            tx          <= 1'b1;
            busy        <= 1'b0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            idx         <= idx_next;
            shifter     <= shifter_next;
            tx          <= tx_next;
            busy        <= busy_next;
            frame_valid <= load;
            if (load) begin
                frame_out <= hold_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    load       = 1'b1;
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (idx == IDX_LAST) begin
                        state_next = ST_STOP;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_STOP: begin
                // A character already waiting chains straight into the next start bit.
                if (bit_done) begin
                    cnt_next = '0;
                    if (hold_full) begin
                        load       = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // Outputs are precomputed from the next state so tx and busy come straight off flops.
    always_comb begin
        shifter_next = load ? hold_data : shifter;
        busy_next    = (state_next != ST_IDLE);
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shifter_next[idx_next];
            default:  tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Self-checking bench: frame-timeline reference model compared every cycle,
// plus literal frame checks, back-to-back, mid-frame reset and a 1-clock-per-bit build.
module tb_parity_tx_ctrl;
    import parity_tx_ctrl_pkg::*;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] in_data = 7'h00;
    logic       par_mode = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [7:0] frame_out;
    logic       frame_valid;

    logic       in_valid1 = 1'b0;
    logic [6:0] in_data1 = 7'h00;
    logic       par_mode1 = 1'b0;
    logic       in_ready1;
    logic       tx1;
    logic       busy1;
    logic [7:0] fo1;
    logic       fv1;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    parity_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .par_mode    (par_mode),
        .tx          (tx),
        .busy        (busy),
        .frame_out   (frame_out),
        .frame_valid (frame_valid)
    );

    parity_tx_ctrl #(.CLKS_PER_BIT(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .in_data     (in_data1),
        .par_mode    (par_mode1),
        .tx          (tx1),
        .busy        (busy1),
        .frame_out   (fo1),
        .frame_valid (fv1)
    );

    // Reference: a pending slot plus a running frame described only by its elapsed cycle count.
    logic       m_full, m_active, m_fv;
    logic [7:0] m_hold, m_word, m_fo;
    int         m_t;
    logic       n_full, n_active, n_fv;
    logic [7:0] n_hold, n_word, n_fo;
    int         n_t;
    logic [9:0] exp_frame;
    logic       exp_tx;

    always_comb begin
        n_full   = m_full;
        n_hold   = m_hold;
        n_active = m_active;
        n_t      = m_t;
        n_word   = m_word;
        n_fo     = m_fo;
        n_fv     = 1'b0;
        if (m_active) begin
            n_t = m_t + 1;
            if (n_t == FRAME_BITS * C) n_active = 1'b0;
        end
        if (!n_active && m_full) begin
            n_word   = m_hold;
            n_fo     = m_hold;
            n_fv     = 1'b1;
            n_active = 1'b1;
            n_t      = 0;
            n_full   = 1'b0;
        end
        if (in_valid && !m_full) begin
            n_full = 1'b1;
            n_hold = {(^in_data) ^ par_mode, in_data};
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full   <= 1'b0;
            m_hold   <= 8'h00;
            m_active <= 1'b0;
            m_t      <= 0;
            m_word   <= 8'h00;
            m_fo     <= 8'h00;
            m_fv     <= 1'b0;
        end else begin
            m_full   <= n_full;
            m_hold   <= n_hold;
            m_active <= n_active;
            m_t      <= n_t;
            m_word   <= n_word;
            m_fo     <= n_fo;
            m_fv     <= n_fv;
        end
    end

    always_comb begin
        exp_frame = {1'b1, m_word, 1'b0} >> (m_t / C);
        exp_tx    = m_active ? exp_frame[0] : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en && !rst) begin
            checkOutput("cycle {rdy,tx,busy,fv,fo}",
                        16'({in_ready, tx, busy, frame_valid, frame_out}),
                        16'({~m_full, exp_tx, m_active, m_fv, m_fo}));
        end
    end

    // Presents one character; while the slot is full the data lines carry junk that must be ignored.
    task automatic applyStimulus(input logic [6:0] d, input logic m, input logic keep);
        int w = 0;
        in_valid = 1'b1;
        while (!in_ready && w < 500) begin
            in_data  = 7'($urandom);
            par_mode = 1'($urandom);
            @(negedge clk);
            w++;
        end
        if (!in_ready) checkOutput("handshake timeout", 16'(in_ready), 16'd1);
        in_data  = d;
        par_mode = m;
        @(negedge clk);
        if (!keep) begin
            in_valid = 1'b0;
            in_data  = 7'($urandom);
            par_mode = 1'($urandom);
        end
    endtask

    task automatic captureFrame(output logic [9:0] bits, output int busy_cyc,
                                output int fv_cnt, output logic [7:0] fo);
        int w = 0;
        bits = '0;
        busy_cyc = 0;
        fv_cnt = 0;
        fo = '0;
        while (frame_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (frame_valid !== 1'b1) begin
            checkOutput("frame start timeout", 16'(frame_valid), 16'd1);
            return;
        end
        fo = frame_out;
        while (busy === 1'b1 && busy_cyc < 400) begin
            if (busy_cyc % C == 0) bits = bits | (10'(tx) << (busy_cyc / C));
            if (frame_valid) fv_cnt++;
            busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic sendAndCheck(input logic [6:0] d, input logic m, input logic [7:0] exp_word,
                                input logic [9:0] exp_bits, input string tag);
        logic [9:0] bits;
        int         bc, fc;
        logic [7:0] fo;
        applyStimulus(d, m, 1'b0);
        captureFrame(bits, bc, fc, fo);
        checkOutput({tag, " frame_out"}, 16'(fo), 16'(exp_word));
        checkOutput({tag, " serial bits"}, 16'(bits), 16'(exp_bits));
        checkOutput({tag, " busy cycles"}, 16'(bc), 16'(FRAME_BITS * C));
        checkOutput({tag, " frame_valid pulses"}, 16'(fc), 16'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [9:0] bits;
        int         bc, fc, w, t40, t80, t39;

        repeat (3) @(negedge clk);
        checkOutput("reset state", 16'({in_ready, tx, busy, frame_valid, frame_out}),
                    16'({1'b1, 1'b1, 1'b0, 1'b0, 8'h00}));
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        sendAndCheck(7'h41, EVEN, 8'h41, 10'b1010000010, "41 even");
        sendAndCheck(7'h41, ODD,  8'hC1, 10'b1110000010, "41 odd");
        sendAndCheck(7'h7F, EVEN, 8'hFF, 10'b1111111110, "7F even");
        sendAndCheck(7'h00, ODD,  8'h80, 10'b1100000000, "00 odd");
        sendAndCheck(7'h00, EVEN, 8'h00, 10'b1000000000, "00 even");

        // Three characters with in_valid held high throughout.
        bc = 0; fc = 0; t39 = 0; t40 = 1; t80 = 1;
        fork
            begin
                applyStimulus(7'h12, EVEN, 1'b1);
                applyStimulus(7'h34, ODD,  1'b1);
                applyStimulus(7'h56, EVEN, 1'b0);
            end
            begin
                w = 0;
                while (frame_valid !== 1'b1 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                while (busy === 1'b1 && bc < 400) begin
                    if (frame_valid) fc++;
                    if (bc == 39) t39 = int'(tx);
                    if (bc == 40) t40 = int'(tx);
                    if (bc == 80) t80 = int'(tx);
                    bc++;
                    @(negedge clk);
                end
            end
        join
        checkOutput("b2b span cycles", 16'(bc), 16'd120);
        checkOutput("b2b frame count", 16'(fc), 16'd3);
        checkOutput("b2b last stop tx", 16'(t39), 16'd1);
        checkOutput("b2b 2nd start tx", 16'(t40), 16'd0);
        checkOutput("b2b 3rd start tx", 16'(t80), 16'd0);

        // Reset in the middle of data bit 3 with a second character waiting.
        applyStimulus(7'h41, EVEN, 1'b0);
        w = 0;
        while (frame_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        applyStimulus(7'h3C, ODD, 1'b0);
        w = 0;
        while (!(m_active && m_t == 17) && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("tx in data bit 3", 16'(tx), 16'd0);
        rst = 1'b1;
        #1;
        checkOutput("async reset mid-frame", 16'({in_ready, tx, busy, frame_valid, frame_out}),
                    16'({1'b1, 1'b1, 1'b0, 1'b0, 8'h00}));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("held char discarded", 16'(busy), 16'd0);
        sendAndCheck(7'h2A, ODD, 8'h2A, 10'b1001010100, "post-reset 2A odd");

        for (int k = 0; k < 25; k++) begin
            applyStimulus(7'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_valid = 1'b0;
        w = 0;
        while (!(busy === 1'b0 && in_ready === 1'b1) && w < 500) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drain to idle", 16'({busy, in_ready}), 16'b01);

        // One clock per bit build.
        in_valid1 = 1'b1;
        in_data1  = 7'h55;
        par_mode1 = ODD;
        @(negedge clk);
        in_valid1 = 1'b0;
        w = 0;
        while (fv1 !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("cpb1 frame_out", 16'(fo1), 16'hD5);
        bits = '0;
        bc = 0;
        while (busy1 === 1'b1 && bc < 50) begin
            bits = bits | (10'(tx1) << bc);
            bc++;
            @(negedge clk);
        end
        checkOutput("cpb1 serial bits", 16'(bits), 16'(10'b1110101010));
        checkOutput("cpb1 busy cycles", 16'(bc), 16'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parity_tx_ctrl.md
# parity_tx_ctrl

Sequencer for the parity generator datapath: accepts 7-bit characters over a valid/ready handshake, appends a parity bit (even or odd, selected per character), and serialises the resulting 8-bit word as an asynchronous frame (start, 8 data LSB first, stop). It sits between a character source and the serial output pin, and exposes each framed byte in parallel for monitoring.

## Interface
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range ≥ 1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  source presents a character
- in_ready  out  1  holding register empty; a transfer occurs on a rising edge with in_valid && in_ready
- in_data  in  7  character to send
- par_mode  in  1  0 = even parity (total ones in 8 bits even), 1 = odd; sampled with in_data at transfer
- tx  out  1  serial output, idle high
- busy  out  1  frame in progress (FSM not IDLE)
- frame_out  out  8  {parity, data[6:0]} of the frame most recently started
- frame_valid  out  1  one-cycle pulse when frame_out updates

## Operation
- Parity bit = ^in_data XOR par_mode, computed at transfer and stored with data in a 1-entry holding register (hold_data[7:0], hold_full).
- in_ready = ~hold_full (combinational from register only; no dependence on in_valid).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If hold_full: load shifter from holding, clear hold_full, frame_out ← hold_data, frame_valid=1, go START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx = shifter[idx], CLKS_PER_BIT cycles per bit; after idx 7 go STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle: if hold_full, load as in IDLE and go directly to START (no idle gap); else go IDLE.
- A transfer may occur in any state while hold_full=0, including during a load cycle's following edge; load and transfer never coincide because load requires hold_full=1 and transfer requires hold_full=0.
- in_data/par_mode changes while in_ready=0 have no effect.
- Reset: tx=1, busy=0, in_ready=1, hold_full=0, frame_out=8'h00, frame_valid=0, FSM IDLE, counters 0. Reset mid-frame aborts the frame; tx returns high asynchronously and the held character is discarded.

## Timing
- Transfer at edge E0 → hold_full=1 after E0. Load at E1 (FSM IDLE): tx=0, busy=1, frame_valid=1 for one cycle after E1.
- Frame length exactly 10·CLKS_PER_BIT cycles from start-bit leading edge to end of stop bit.
- Back-to-back: with holding refilled before stop bit ends, next start bit begins the cycle after the last stop cycle; continuous stream has period 10·CLKS_PER_BIT.
- Bit counter width $clog2(CLKS_PER_BIT) (min 1); bit index 3 bits; all outputs registered except in_ready.

## Structure
- Shared package: FSM state encoding (IDLE/START/DATA/STOP, 2 bits), FRAME_BITS=10, DATA_BITS=7, parity-mode constants EVEN=0/ODD=1.
- One sub-module: par_calc (combinational, 7-bit data + mode → 8-bit {parity,data}), instanced at the holding-register input.

## Test plan
- CLKS_PER_BIT=4, send 7'h41 even → frame_out 8'h41, frame_valid one cycle; tx sequence 0,1,0,0,0,0,0,1,0,1, each held 4 cycles; busy high 40 cycles.
- Send 7'h41 odd → frame_out 8'hC1, parity bit (9th serial bit) = 1.
- Send 7'h7F even → 8'hFF; 7'h00 odd → 8'h80; 7'h00 even → 8'h00.
- Hold in_valid high with 3 characters queued back-to-back → in_ready low 1 cycle after each transfer, reasserts at each load; three frames span exactly 120 cycles with no tx-high gap between stop and next start.
- Assert rst during DATA bit 3 → tx=1, busy=0, in_ready=1, frame_out=8'h00 immediately; next character transmits a complete, correct frame.
- CLKS_PER_BIT=1 build: 7'h55 odd → 8'hD5; frame occupies exactly 10 cycles.
